// File: rtl/compressor_pkg.sv
// Shared defaults, FSM encoding and constants for the LZ77-style compressor.
// Imported by compressor and match_finder.
package compressor_pkg;

    localparam int Q_LENGTH_DEF = 10;
    localparam int Q_BITS_DEF   = 4;
    localparam int L_LENGTH_DEF = 5;
    localparam int L_BITS_DEF   = 3;

    // Shortest back-reference worth emitting; shorter ones become literals.
    localparam int MIN_MATCH    = 2;

    localparam int FIFO_DEPTH   = 16;
    localparam int FIFO_CNT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEARCH,
        ST_EMIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/compressor_match_finder.sv
// Combinational longest-match search of the look-ahead prefix against history.
// Ports: hist_i/hist_cnt_i (history, index 0 = newest), la_i/la_cnt_i, dist_o/len_o.
module match_finder
    import compressor_pkg::*;
#(
    parameter int Q_LENGTH = Q_LENGTH_DEF,
    parameter int Q_BITS   = Q_BITS_DEF,
    parameter int L_LENGTH = L_LENGTH_DEF,
    parameter int L_BITS   = L_BITS_DEF
) (
    input  logic [Q_LENGTH-1:0][7:0] hist_i,
    input  logic [Q_BITS:0]          hist_cnt_i,
    input  logic [L_LENGTH-1:0][7:0] la_i,
    input  logic [L_BITS:0]          la_cnt_i,
    output logic [Q_BITS:0]          dist_o,
    output logic [L_BITS:0]          len_o
);

    int best_d;
    int best_l;
    int run;
    logic alive;

    // Look-ahead byte k at distance d pairs with history slot d-1-k; the
    // run is capped at d so only already-consumed bytes are referenced.
    always_comb begin
        best_d = 0;
        best_l = 0;
        run    = 0;
        alive  = 1'b0;
        for (int d = 1; d <= Q_LENGTH; d++) begin
            run   = 0;
            alive = 1'b1;
            for (int k = 0; k < L_LENGTH; k++) begin
                if (alive && k < d && k < int'(la_cnt_i)
                    && (d - 1 - k) < int'(hist_cnt_i)) begin
                    if (la_i[k] == hist_i[d-1-k]) begin
                        run = run + 1;
                    end else begin
                        alive = 1'b0;
                    end
                end else begin
                    alive = 1'b0;
                end
            end
            // Strict compare keeps the smallest distance on ties.
            if (run > best_l) begin
                best_l = run;
                best_d = d;
            end
        end
        dist_o = (Q_BITS+1)'(best_d);
        len_o  = (L_BITS+1)'(best_l);
    end

endmodule

// File: rtl/compressor.sv
// LZ77-style byte compressor: loads an input FIFO, streams tokens.
// Ports: clock/reset/compress, bytes_in/valid_bytes_in load, byte_n/get_byte_n fetch, token outputs.
module compressor
    import compressor_pkg::*;
#(
    parameter int Q_LENGTH = Q_LENGTH_DEF,
    parameter int Q_BITS   = Q_BITS_DEF,
    parameter int L_LENGTH = L_LENGTH_DEF,
    parameter int L_BITS   = L_BITS_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              compress,
    input  logic [63:0]       bytes_in,
    input  logic [3:0]        valid_bytes_in,
    input  logic [7:0]        byte_n,
    input  logic              byte_n_valid,
    output logic [L_BITS-1:0] get_byte_n,
    output logic [Q_BITS:0]   distance,
    output logic [L_BITS:0]   length,
    output logic [7:0]        literal,
    output logic              output_valid
);

    localparam logic [FIFO_CNT_W-1:0] FIFO_MAX = FIFO_CNT_W'(FIFO_DEPTH);
    localparam logic [L_BITS:0]       LA_MAX   = (L_BITS+1)'(L_LENGTH);
    localparam logic [Q_BITS:0]       H_MAX    = (Q_BITS+1)'(Q_LENGTH);
    localparam logic [L_BITS:0]       MIN_LEN  = (L_BITS+1)'(MIN_MATCH);

    state_e state_q;

    logic [FIFO_DEPTH-1:0][7:0] fifo_q, fifo_d;
    logic [FIFO_CNT_W-1:0]      fcnt_q, fcnt_d;
    logic [L_LENGTH-1:0][7:0]   la_q, la_d;
    logic [L_BITS:0]            lcnt_q, lcnt_d;
    logic [Q_LENGTH-1:0][7:0]   hist_q, hist_d;
    logic [Q_BITS:0]            hcnt_q, hcnt_d;
    logic [L_BITS-1:0]          ext_q;
    logic [Q_BITS:0]            best_d_q;
    logic [L_BITS:0]            best_l_q;
    logic [Q_BITS:0]            dist_q;
    logic [L_BITS:0]            len_q;
    logic [7:0]                 lit_q;
    logic                       ov_q;

    logic [Q_BITS:0] mf_dist;
    logic [L_BITS:0] mf_len;

    logic            fifo_has;
    logic            src_avail;
    logic            la_full;
    logic            fill_take;
    logic            take_fifo;
    logic            take_ext;
    logic            do_emit;
    logic            is_match;
    logic [7:0]      in_byte;
    logic [L_BITS:0] shift_n;
    int              nload;
    int              sn;
    int              hsum;

    match_finder #(
        .Q_LENGTH (Q_LENGTH),
        .Q_BITS   (Q_BITS),
        .L_LENGTH (L_LENGTH),
        .L_BITS   (L_BITS)
    ) u_match (
        .hist_i     (hist_q),
        .hist_cnt_i (hcnt_q),
        .la_i       (la_q),
        .la_cnt_i   (lcnt_q),
        .dist_o     (mf_dist),
        .len_o      (mf_len)
    );

    assign fifo_has  = (fcnt_q != '0);
    assign src_avail = fifo_has || byte_n_valid;
    assign la_full   = (lcnt_q == LA_MAX);
    assign fill_take = compress && (state_q == ST_FILL) && !la_full && src_avail;
    assign take_fifo = fill_take && fifo_has;
    assign take_ext  = fill_take && !fifo_has;
    assign do_emit   = compress && (state_q == ST_EMIT);
    assign in_byte   = fifo_has ? fifo_q[0] : byte_n;
    assign is_match  = (best_l_q >= MIN_LEN);
    assign shift_n   = is_match ? best_l_q : (L_BITS+1)'(1);

    // Input FIFO: loads only while idle-loading, pops only while filling,
    // so the two never collide in one cycle.
    always_comb begin
        fifo_d = fifo_q;
        fcnt_d = fcnt_q;
        nload  = (valid_bytes_in > 4'd8) ? 8 : int'(valid_bytes_in);
        if (!compress) begin
            for (int i = 0; i < 8; i++) begin
                if (i < nload && fcnt_d < FIFO_MAX) begin
                    fifo_d[fcnt_d[FIFO_CNT_W-2:0]] = bytes_in[63-8*i -: 8];
                    fcnt_d = fcnt_d + FIFO_CNT_W'(1);
                end
            end
        end else if (take_fifo) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
            fifo_d[FIFO_DEPTH-1] = 8'h00;
            fcnt_d = fcnt_q - FIFO_CNT_W'(1);
        end
    end

    // Look-ahead and history: append on fetch, move shift_n bytes on emit.
    always_comb begin
        la_d   = la_q;
        lcnt_d = lcnt_q;
        hist_d = hist_q;
        hcnt_d = hcnt_q;
        sn     = int'(shift_n);
        hsum   = int'(hcnt_q) + sn;
        if (take_fifo || take_ext) begin
            la_d[int'(lcnt_q)] = in_byte;
            lcnt_d = lcnt_q + (L_BITS+1)'(1);
        end else if (do_emit) begin
            for (int i = 0; i < Q_LENGTH; i++) begin
                if (i < sn) begin
                    hist_d[i] = la_q[sn-1-i];
                end else begin
                    hist_d[i] = hist_q[i-sn];
                end
            end
            for (int i = 0; i < L_LENGTH; i++) begin
                if (i + sn < L_LENGTH) begin
                    la_d[i] = la_q[i+sn];
                end else begin
                    la_d[i] = 8'h00;
                end
            end
            lcnt_d = lcnt_q - shift_n;
            hcnt_d = (hsum > Q_LENGTH) ? H_MAX : (Q_BITS+1)'(hsum);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fifo_q   <= '0;
            fcnt_q   <= '0;
            la_q     <= '0;
            lcnt_q   <= '0;
            hist_q   <= '0;
            hcnt_q   <= '0;
            ext_q    <= '0;
            best_d_q <= '0;
            best_l_q <= '0;
            dist_q   <= '0;
            len_q    <= '0;
            lit_q    <= '0;
            ov_q     <= 1'b0;
        end else begin
            fifo_q <= fifo_d;
            fcnt_q <= fcnt_d;
            la_q   <= la_d;
            lcnt_q <= lcnt_d;
            hist_q <= hist_d;
            hcnt_q <= hcnt_d;
            ov_q   <= 1'b0;
            if (take_ext) begin
                ext_q <= ext_q + L_BITS'(1);
            end
            if (!compress) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: state_q <= ST_FILL;
                    ST_FILL: begin
                        // Nothing left to code at all: skip straight to DONE.
                        if (la_full || !src_avail) begin
                            state_q <= (lcnt_q == '0) ? ST_DONE : ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        best_d_q <= mf_dist;
                        best_l_q <= mf_len;
                        state_q  <= ST_EMIT;
                    end
                    ST_EMIT: begin
                        ov_q <= 1'b1;
                        if (is_match) begin
                            dist_q <= best_d_q;
                            len_q  <= best_l_q;
                            lit_q  <= 8'h00;
                        end else begin
                            dist_q <= '0;
                            len_q  <= '0;
                            lit_q  <= la_q[0];
                        end
                        if (lcnt_d != '0 || fifo_has || byte_n_valid) begin
                            state_q <= ST_FILL;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: state_q <= ST_DONE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign get_byte_n   = ext_q;
    assign distance     = dist_q;
    assign length       = len_q;
    assign literal      = lit_q;
    assign output_valid = ov_q;

endmodule

// File: tb/tb_compressor.sv
// Directed, table-driven bench for compressor.
// Tokens are captured per scenario and compared against a hand-built table.
module tb_compressor;
    import compressor_pkg::*;

    logic        clock;
    logic        reset;
    logic        compress;
    logic [63:0] bytes_in;
    logic [3:0]  valid_bytes_in;
    logic [7:0]  byte_n;
    logic        byte_n_valid;
    logic [2:0]  get_byte_n;
    logic [4:0]  distance;
    logic [3:0]  length;
    logic [7:0]  literal;
    logic        output_valid;

    logic ext_en;
    int   ext_n;

    int nvec;
    int nfail;
    int bad_len;

    typedef struct {
        int         scen;
        logic [4:0] d;
        logic [3:0] l;
        logic [7:0] lit;
    } vec_t;

    typedef struct packed {
        logic [4:0] d;
        logic [3:0] l;
        logic [7:0] lit;
    } tok_t;

    vec_t vt[$];
    tok_t tokq[$];

    compressor dut (
        .clock          (clock),
        .reset          (reset),
        .compress       (compress),
        .bytes_in       (bytes_in),
        .valid_bytes_in (valid_bytes_in),
        .byte_n         (byte_n),
        .byte_n_valid   (byte_n_valid),
        .get_byte_n     (get_byte_n),
        .distance       (distance),
        .length         (length),
        .literal        (literal),
        .output_valid   (output_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign byte_n_valid = ext_en && (int'(get_byte_n) < ext_n);

    always @(negedge clock) begin
        if (output_valid) begin
            tokq.push_back('{distance, length, literal});
            if (length > 4'(distance)) bad_len = bad_len + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        compress = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load(input logic [63:0] b, input logic [3:0] n);
        bytes_in       = b;
        valid_bytes_in = n;
        @(negedge clock);
        valid_bytes_in = 4'd0;
        bytes_in       = '0;
    endtask

    task automatic run_to_done(input string name);
        compress = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (dut.state_q == ST_DONE) break;
        end
        chk({name, "_done"}, 32'(dut.state_q), 32'(ST_DONE));
        @(negedge clock);
        compress = 1'b0;
        @(negedge clock);
    endtask

    task automatic check_tokens(input int scen);
        int idx;
        idx = 0;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].scen == scen) begin
                if (idx < tokq.size()) begin
                    chk($sformatf("s%0d_tok%0d", scen, idx),
                        32'(tokq[idx]),
                        32'(tok_t'({vt[i].d, vt[i].l, vt[i].lit})));
                end else begin
                    nvec  = nvec + 1;
                    nfail = nfail + 1;
                    $display("FAIL s%0d_tok%0d: got none expected %0h/%0h/%0h",
                             scen, idx, vt[i].d, vt[i].l, vt[i].lit);
                end
                idx = idx + 1;
            end
        end
        chk($sformatf("s%0d_count", scen), 32'(tokq.size()), 32'(idx));
        tokq.delete();
    endtask

    task automatic add_lit(input int scen, input logic [7:0] b);
        vt.push_back('{scen, 5'd0, 4'd0, b});
    endtask

    initial begin
        logic [7:0] b;
        nvec           = 0;
        nfail          = 0;
        bad_len        = 0;
        reset          = 1'b1;
        compress       = 1'b0;
        bytes_in       = '0;
        valid_bytes_in = '0;
        byte_n         = 8'h00;
        ext_en         = 1'b0;
        ext_n          = 0;

        // Scenario 2: repeat with one back-reference.
        add_lit(2, 8'h00);
        add_lit(2, 8'h11);
        add_lit(2, 8'h22);
        vt.push_back('{2, 5'd3, 4'd3, 8'h00});
        add_lit(2, 8'h33);
        // Scenario 3: twelve distinct literals.
        for (int i = 0; i < 12; i++) begin
            b = 8'(i * 17);
            add_lit(3, b);
        end
        // Scenario 4: run of AA from the external stream.
        add_lit(4, 8'hAA);
        add_lit(4, 8'hAA);
        vt.push_back('{4, 5'd2, 4'd2, 8'h00});
        vt.push_back('{4, 5'd2, 4'd2, 8'h00});
        // Scenario 5: zero-valid load, >8 count, FIFO overflow.
        add_lit(5, 8'hA1);
        add_lit(5, 8'hA2);
        add_lit(5, 8'hA3);
        for (int i = 0; i < 8; i++) add_lit(5, 8'(8'hB0 + i));
        for (int i = 0; i < 5; i++) add_lit(5, 8'(8'hC0 + i));

        // Scenario 1: reset with a load pending, then idle.
        bytes_in       = 64'h0102030405060708;
        valid_bytes_in = 4'd8;
        repeat (3) @(negedge clock);
        valid_bytes_in = 4'd0;
        reset          = 1'b0;
        @(negedge clock);
        chk("rst_dist", 32'(distance), 32'd0);
        chk("rst_len", 32'(length), 32'd0);
        chk("rst_lit", 32'(literal), 32'd0);
        chk("rst_ov", 32'(output_valid), 32'd0);
        chk("rst_get", 32'(get_byte_n), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        run_to_done("s1");
        check_tokens(1);

        do_reset();
        load(64'h0011220011223300, 4'd7);
        run_to_done("s2");
        check_tokens(2);
        chk("s2_get", 32'(get_byte_n), 32'd0);

        do_reset();
        load(64'h0011223344556677, 4'd8);
        load(64'h8899AABB00000000, 4'd4);
        run_to_done("s3");
        check_tokens(3);

        do_reset();
        ext_en = 1'b1;
        ext_n  = 6;
        byte_n = 8'hAA;
        run_to_done("s4");
        check_tokens(4);
        chk("s4_get", 32'(get_byte_n), 32'd6);
        chk("s4_len_le_dist", 32'(bad_len), 32'd0);
        ext_en = 1'b0;

        do_reset();
        load(64'hA1A2A30000000000, 4'd3);
        load(64'hFFFFFFFFFFFFFFFF, 4'd0);
        load(64'hB0B1B2B3B4B5B6B7, 4'd15);
        load(64'hC0C1C2C3C4C5C6C7, 4'd8);
        run_to_done("s5");
        check_tokens(5);

        // Scenario 6: reset between tokens.
        do_reset();
        load(64'h1020304050607080, 4'd8);
        compress = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (output_valid) break;
        end
        chk("s6_first_ov", 32'(output_valid), 32'd1);
        chk("s6_first_lit", 32'(literal), 32'h10);
        reset    = 1'b1;
        compress = 1'b0;
        @(posedge clock);
        #1;
        chk("s6_rst_ov", 32'(output_valid), 32'd0);
        chk("s6_rst_lit", 32'(literal), 32'd0);
        chk("s6_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;
        tokq.delete();
        repeat (10) @(negedge clock);
        chk("s6_quiet", 32'(tokq.size()), 32'd0);
        run_to_done("s6");
        check_tokens(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/compressor.md
COMPRESSOR -- requirements
Module: compressor

Interface
REQ-001 SHALL have parameter Q_LENGTH, default 10, history (search) window depth in bytes.
REQ-002 SHALL have parameter Q_BITS, default 4, index width for the history window.
REQ-003 SHALL have parameter L_LENGTH, default 5, look-ahead buffer depth in bytes and maximum match length.
REQ-004 SHALL have parameter L_BITS, default 3, index width for the look-ahead buffer.
REQ-005 SHALL have ports: clock in 1, the single clock; reset in 1, synchronous active-high; compress in 1, run enable.
REQ-006 SHALL have ports: bytes_in in 64, packed load bytes, MSB byte first; valid_bytes_in in 4, count 0..8 of valid bytes in bytes_in.
REQ-007 SHALL have ports: byte_n in 8, fetched external byte; byte_n_valid in 1, byte_n valid (0 = external stream exhausted); get_byte_n out L_BITS, external fetch index.
REQ-008 SHALL have ports: distance out Q_BITS+1, match distance; length out L_BITS+1, match length; literal out 8, literal byte; output_valid out 1, token strobe.

Function
- Load
REQ-009 SHALL, while compress=0, append the first valid_bytes_in bytes of bytes_in (bits 63:56 first) to a 16-byte input FIFO each cycle; bytes beyond FIFO capacity are dropped; valid_bytes_in>8 is treated as 8.
- Compress
REQ-010 SHALL, with compress=1, keep the look-ahead buffer filled: one byte per cycle from the input FIFO; once the FIFO is empty, from byte_n.
REQ-011 SHALL drive get_byte_n as a wrapping counter of external bytes accepted, starting at 0 after reset; byte_n is sampled the same cycle and accepted only when byte_n_valid=1.
REQ-012 SHALL use the FSM IDLE -> FILL -> SEARCH -> EMIT -> (FILL | DONE).
REQ-013 SHALL move IDLE->FILL on compress=1; FILL->SEARCH when the look-ahead is full or no source remains; SEARCH->EMIT next cycle.
REQ-014 SHALL move EMIT->FILL if bytes remain or a source can still supply bytes, else EMIT->DONE; DONE->IDLE when compress=0.
REQ-015 SHALL, in SEARCH, find the longest match of the look-ahead prefix against the history window, with distance 1..Q_LENGTH, length<=min(distance, L_LENGTH, look-ahead fill), and ties broken by smallest distance.
REQ-016 SHALL, in EMIT with best length>=2, pulse output_valid for one cycle with distance=d, length=len, literal=0, then shift len bytes from look-ahead into history.
REQ-017 SHALL otherwise emit a literal token (distance=0, length=0, literal=look-ahead byte 0) and shift one byte.
REQ-018 SHALL keep the history window as the last Q_LENGTH consumed bytes, oldest discarded; empty history slots never match.
REQ-019 SHALL hold outputs between tokens with output_valid=0; deasserting compress mid-run returns to IDLE, keeping buffers.

Reset
REQ-020 SHALL, on reset=1 at a clock edge, clear both FIFOs, the history window, the FSM (IDLE) and get_byte_n; distance, length, literal and output_valid SHALL be 0; reset overrides load and compress activity in the same cycle.

Structure
REQ-021 SHALL place default parameter values, FSM state encoding and MIN_MATCH=2 in shared package compressor_pkg.
REQ-022 SHALL implement the match search as one sub-module, match_finder, combinational over history and look-ahead and returning {distance, length}.

Verification
REQ-023 Reset then idle -> all outputs 0, get_byte_n=0.
REQ-024 Load 00 11 22 00 11 22 33, byte_n_valid=0, compress=1 -> tokens lit 00, lit 11, lit 22, (d=3,len=3), lit 33, then DONE.
REQ-025 Load 0x0011223344556677 (valid 8) then 0x8899AABB00000000 (valid 4) -> twelve literal tokens 00..BB in order.
REQ-026 Empty FIFO, external bytes AA AA AA AA AA AA -> lit AA, (d=1,len=1 rejected) lit AA, (d=2,len=2), (d=2,len=2); no token has len>distance.
REQ-027 Assert reset between tokens -> outputs 0 next cycle, FSM IDLE, no further tokens until compress.
REQ-028 valid_bytes_in=0 load cycle -> FIFO unchanged.
